// File: rtl/control_dec_exc_pkg.sv
// Shared pipeline definitions for the Decode->Execute control path.
package control_dec_exc_pkg;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int ALU_CTRL_WIDTH     = 3;
  localparam int RES_SRC_WIDTH      = 2;

  localparam logic [RES_SRC_WIDTH-1:0] RES_ALU = 2'b00;
  localparam logic [RES_SRC_WIDTH-1:0] RES_MEM = 2'b01;
  localparam logic [RES_SRC_WIDTH-1:0] RES_PC4 = 2'b10;
endpackage

// File: rtl/control_dec_exc_load_use_detect.sv
// Load-use hazard detect: a valid load in Execute whose non-x0 destination
// is read by the instruction now in Decode.
module load_use_detect
  import control_dec_exc_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                      ValidE,
  input  logic [RES_SRC_WIDTH-1:0]  ResultSrcE,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  output logic                      lwStall
);

  // Rs2 is compared even for stores: conservative, costs at most one bubble.
  assign lwStall = ValidE && (ResultSrcE == RES_MEM) && (RdE != '0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

endmodule

// File: rtl/control_dec_exc.sv
// Decode->Execute control register with load-use bubble insertion,
// fetch/decode stall and flush strobes, and a saturating bubble counter.
module control_dec_exc
  import control_dec_exc_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RegWriteD,
  input  logic [RES_SRC_WIDTH-1:0]  ResultSrcD,
  input  logic                      MemWriteD,
  input  logic                      JumpD,
  input  logic                      BranchD,
  input  logic [ALU_CTRL_WIDTH-1:0] ALUControlD,
  input  logic                      ALUSrcD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic                      PCSrcE,
  output logic                      RegWriteE,
  output logic [RES_SRC_WIDTH-1:0]  ResultSrcE,
  output logic                      MemWriteE,
  output logic                      JumpE,
  output logic                      BranchE,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
  output logic                      ALUSrcE,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      ValidE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic [CNT_WIDTH-1:0]      BubbleCount
);

  logic lw_stall;
  logic bubble;

  load_use_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_load_use_detect (
    .ValidE    (ValidE),
    .ResultSrcE(ResultSrcE),
    .RdE       (RdE),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .lwStall   (lw_stall)
  );

  // A redirect squashes the Decode instruction, so it is never held.
  assign StallF = lw_stall & ~PCSrcE;
  assign StallD = lw_stall & ~PCSrcE;
  assign FlushD = PCSrcE;
  assign bubble = lw_stall | PCSrcE;

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= RES_ALU;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      ALUSrcE     <= 1'b0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      ValidE      <= 1'b0;
      BubbleCount <= '0;
    end else if (bubble) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= RES_ALU;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      ALUSrcE     <= 1'b0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      ValidE      <= 1'b0;
      if (BubbleCount != '1)
        BubbleCount <= BubbleCount + CNT_WIDTH'(1);
    end else begin
      RegWriteE   <= RegWriteD;
      ResultSrcE  <= ResultSrcD;
      MemWriteE   <= MemWriteD;
      JumpE       <= JumpD;
      BranchE     <= BranchD;
      ALUControlE <= ALUControlD;
      ALUSrcE     <= ALUSrcD;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
      ValidE      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_dec_exc.sv
// Bench for control_dec_exc: cycle table with scoreboard, plus a
// saturation sequence on a narrow-counter instance.
module tb_control_dec_exc;
  import control_dec_exc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset2;
  logic       RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, PCSrcE;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic [4:0] Rs1D, Rs2D, RdD;

  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        StallF, StallD, FlushD;
  logic [15:0] BubbleCount;

  logic        RegWriteE2, MemWriteE2, JumpE2, BranchE2, ALUSrcE2, ValidE2;
  logic [1:0]  ResultSrcE2;
  logic [2:0]  ALUControlE2;
  logic [4:0]  Rs1E2, Rs2E2, RdE2;
  logic        StallF2, StallD2, FlushD2;
  logic [1:0]  BubbleCount2;

  control_dec_exc dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .BubbleCount(BubbleCount)
  );

  control_dec_exc #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset2),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE2), .ResultSrcE(ResultSrcE2), .MemWriteE(MemWriteE2),
    .JumpE(JumpE2), .BranchE(BranchE2), .ALUControlE(ALUControlE2), .ALUSrcE(ALUSrcE2),
    .Rs1E(Rs1E2), .Rs2E(Rs2E2), .RdE(RdE2), .ValidE(ValidE2),
    .StallF(StallF2), .StallD(StallD2), .FlushD(FlushD2), .BubbleCount(BubbleCount2)
  );

  typedef struct {
    logic       rst, rw, mw, pc;
    logic [1:0] rs;
    logic [4:0] rs1, rs2, rd;
    logic       st, fl, vld;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          row;
    logic [24:0] ef;
    logic        vld;
    logic [15:0] cnt;
  } exp_t;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  vec_t tbl[18];

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h expected=%0h", nm, row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, rw, input logic [1:0] rs, input logic mw,
                              input logic [4:0] rs1, rs2, rd, input logic pc,
                              input logic st, fl, vld, input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.rw = rw; v.rs = rs; v.mw = mw;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.pc = pc;
    v.st = st; v.fl = fl; v.vld = vld; v.cnt = cnt;
    return v;
  endfunction

  logic rst_seq[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic pc_seq[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  int   cnt_seq[8] = '{0, 1, 2, 3, 3, 3, 0, 1};

  initial begin
    exp_t e, got;
    //               rst rw  rs    mw  rs1 rs2 rd  pc  st  fl  vld cnt
    tbl[0]  = mk(1, 1, 2'b01, 0,  5,  5,  5, 0,  0, 0, 0, 0);  // second reset cycle
    tbl[1]  = mk(0, 1, 2'b00, 0,  1,  2,  3, 0,  0, 0, 1, 0);
    tbl[2]  = mk(0, 1, 2'b01, 0,  2,  0,  5, 0,  0, 0, 1, 0);  // load x5
    tbl[3]  = mk(0, 1, 2'b00, 0,  5,  7,  6, 0,  1, 0, 0, 1);  // use x5 -> bubble
    tbl[4]  = mk(0, 1, 2'b00, 0,  5,  7,  6, 0,  0, 0, 1, 1);  // held instr captured
    tbl[5]  = mk(0, 1, 2'b01, 0,  1,  1,  0, 0,  0, 0, 1, 1);  // load x0
    tbl[6]  = mk(0, 1, 2'b00, 0,  0,  0,  4, 0,  0, 0, 1, 1);  // x0 never stalls
    tbl[7]  = mk(0, 1, 2'b01, 0,  4,  4,  9, 0,  0, 0, 1, 1);  // load x9
    tbl[8]  = mk(0, 0, 2'b00, 1,  1,  9,  0, 0,  1, 0, 0, 2);  // store rs2=x9 stalls
    tbl[9]  = mk(0, 0, 2'b00, 1,  1,  9,  0, 0,  0, 0, 1, 2);
    tbl[10] = mk(0, 1, 2'b01, 0,  3,  3,  7, 0,  0, 0, 1, 2);  // load x7
    tbl[11] = mk(0, 1, 2'b00, 0,  7,  1,  2, 1,  0, 1, 0, 3);  // redirect wins over stall
    tbl[12] = mk(0, 1, 2'b00, 0,  1,  2,  3, 1,  0, 1, 0, 4);  // redirect alone
    tbl[13] = mk(0, 1, 2'b01, 0,  1,  1,  8, 0,  0, 0, 1, 4);  // load x8
    tbl[14] = mk(1, 1, 2'b00, 0,  2,  8,  6, 0,  1, 0, 0, 0);  // reset during stall
    tbl[15] = mk(0, 1, 2'b00, 0,  2,  8,  6, 0,  0, 0, 1, 0);
    tbl[16] = mk(0, 1, 2'b10, 0,  0,  0, 10, 0,  0, 0, 1, 0);  // PC+4 writeback
    tbl[17] = mk(0, 1, 2'b00, 0, 10,  0, 11, 0,  0, 0, 1, 0);  // no stall behind PC+4

    reset = 1'b1; reset2 = 1'b1; PCSrcE = 1'b0;
    RegWriteD = 1'b1; ResultSrcD = 2'b01; MemWriteD = 1'b1; JumpD = 1'b1; BranchD = 1'b1;
    ALUControlD = 3'($urandom); ALUSrcD = 1'b1; Rs1D = 5'd3; Rs2D = 5'd4; RdD = 5'd3;
    @(posedge clk);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; reset2 = tbl[i].rst;
      RegWriteD = tbl[i].rw; ResultSrcD = tbl[i].rs; MemWriteD = tbl[i].mw;
      Rs1D = tbl[i].rs1; Rs2D = tbl[i].rs2; RdD = tbl[i].rd; PCSrcE = tbl[i].pc;
      JumpD = 1'($urandom); BranchD = 1'($urandom);
      ALUControlD = 3'($urandom); ALUSrcD = 1'($urandom);
      #1;
      chk("StallF", i, 32'(StallF), 32'(tbl[i].st));
      chk("StallD", i, 32'(StallD), 32'(tbl[i].st));
      chk("FlushD", i, 32'(FlushD), 32'(tbl[i].fl));
      e.row = i;
      e.vld = tbl[i].vld;
      e.cnt = tbl[i].cnt;
      e.ef  = tbl[i].vld ? {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
                            ALUControlD, ALUSrcD, Rs1D, Rs2D, RdD} : 25'd0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("ValidE", got.row, 32'(ValidE), 32'(got.vld));
      chk("Efields", got.row,
          32'({RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
               ALUControlE, ALUSrcE, Rs1E, Rs2E, RdE}), 32'(got.ef));
      chk("BubbleCount", got.row, 32'(BubbleCount), 32'(got.cnt));
    end

    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reset2 = rst_seq[i];
      PCSrcE = pc_seq[i];
      RegWriteD = 1'b1; ResultSrcD = RES_ALU; MemWriteD = 1'b0;
      Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3;
      @(posedge clk);
      #1;
      chk("BubbleCountSat", i, 32'(BubbleCount2), 32'(cnt_seq[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
